// File: rtl/uart_receiver_if.sv
// Serial-line and byte-output bundle between a UART line source and the receiver.
// The slave modport is the receiver's view; master is the line driver / byte consumer.
`timescale 1ns/1ps
interface uart_receiver_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_error;
  logic       rx_busy;

  modport slave (
    input  rx,
    output rx_data,
    output rx_valid,
    output rx_frame_error,
    output rx_busy
  );

  modport master (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  rx_frame_error,
    input  rx_busy
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchroniser, falling-edge start detect, mid-bit
// sampling from a per-frame bit counter, one-cycle valid / framing-error strobes.
`timescale 1ns/1ps
module uart_receiver #(
  parameter int system_clk_freq     = 100_000_000,
  parameter int baud_rate           = 115200,
  parameter int counter_cycles      = system_clk_freq / baud_rate,
  parameter int half_counter_cycles = counter_cycles / 2
) (
  input  logic           system_clk,
  input  logic           rst,
  uart_receiver_if.slave bus
);
  localparam int CNT_W = $clog2(counter_cycles);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(counter_cycles - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_counter_cycles - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q;
  logic             sync1_q;
  logic             sync2_q;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             ferr_q;
  logic             busy_q;
  logic             start_edge;

  // A start needs the line to have been seen high first, so a stuck-low line never starts.
  assign start_edge = prev_q & ~sync2_q;

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start_edge) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!sync2_q) begin
              state_q <= DATA;
              idx_q   <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= sync2_q;
            idx_q          <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (cnt_q == FULL_LAST) begin
            // Returning to IDLE at mid-stop-bit lets a zero-gap next start be caught.
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (sync2_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.rx_data        = data_q;
  assign bus.rx_valid       = valid_q;
  assign bus.rx_frame_error = ferr_q;
  assign bus.rx_busy        = busy_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at 100 cycles/bit: the sender queues the
// expected strobe (kind, data, cycle) and a negedge monitor checks each strobe.
`timescale 1ns/1ps
module tb_uart_receiver;
  localparam int CLK_FREQ = 10_000_000;
  localparam int BAUD     = 100_000;
  localparam int BIT      = 100;
  localparam int HALF     = 50;
  // pin fall -> T0 is 3 edges; stop sample is T0 + HALF + 9*BIT
  localparam int STOP_LAT = 3 + HALF + 9 * BIT;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic system_clk = 1'b0;
  logic rst        = 1'b1;
  int   cyc        = 0;
  int   n_tests    = 0;
  int   n_fail     = 0;
  logic [7:0] last_good = 8'h00;
  ev_t  exp_q[$];

  uart_receiver_if bus();

  uart_receiver #(
    .system_clk_freq(CLK_FREQ),
    .baud_rate      (BAUD)
  ) dut (
    .system_clk(system_clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 system_clk = ~system_clk;
  always @(posedge system_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge system_clk);
  endtask

  // Called at #1 after a rising edge; returns at #1 after the edge ending the stop bit.
  task automatic send_byte(input logic [7:0] d, input int period,
                           input logic stop_bit, input bit expect_ev);
    ev_t e;
    if (expect_ev) begin
      e.ferr = !stop_bit;
      e.data = stop_bit ? d : last_good;
      e.cyc  = cyc + STOP_LAT;
      exp_q.push_back(e);
      if (stop_bit) last_good = d;
    end
    bus.rx = 1'b0;
    repeat (period) @(posedge system_clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      repeat (period) @(posedge system_clk);
      #1;
    end
    bus.rx = stop_bit;
    repeat (period) @(posedge system_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge system_clk);
    #1;
  endtask

  always @(negedge system_clk) begin
    if (!rst && (bus.rx_valid || bus.rx_frame_error)) begin
      ev_t e;
      $display("[TB] cycle %0d: valid=%0b ferr=%0b data=%02h", cyc,
               bus.rx_valid, bus.rx_frame_error, bus.rx_data);
      chk("no_dual_strobe", int'(bus.rx_valid & bus.rx_frame_error), 0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_event: got valid=%0b ferr=%0b, expected none",
                 bus.rx_valid, bus.rx_frame_error);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind_ferr", int'(bus.rx_frame_error), int'(e.ferr));
        chk("event_data", int'(bus.rx_data), int'(e.data));
        chk("event_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int n;
    bus.rx = 1'b1;
    rst    = 1'b1;
    repeat (3) @(posedge system_clk);
    #1;
    chk("reset_rx_data", int'(bus.rx_data), 0);
    chk("reset_rx_valid", int'(bus.rx_valid), 0);
    chk("reset_rx_ferr", int'(bus.rx_frame_error), 0);
    chk("reset_rx_busy", int'(bus.rx_busy), 0);
    rst = 1'b0;
    idle(5);

    // 1: 0xA5 with busy window T0 .. stop sample
    n = cyc;
    fork
      send_byte(8'hA5, BIT, 1'b1, 1'b1);
      begin
        wait_cyc(n + 2);  chk("busy_before_t0", int'(bus.rx_busy), 0);
        wait_cyc(n + 3);  chk("busy_at_t0", int'(bus.rx_busy), 1);
        wait_cyc(n + STOP_LAT - 1); chk("busy_before_stop", int'(bus.rx_busy), 1);
        wait_cyc(n + STOP_LAT);     chk("busy_after_stop", int'(bus.rx_busy), 0);
      end
    join
    idle(30);

    // 2: 0x00 then 0xFF with zero idle bits
    send_byte(8'h00, BIT, 1'b1, 1'b1);
    send_byte(8'hFF, BIT, 1'b1, 1'b1);
    idle(30);

    // 3: short low glitch aborts at the start-bit sample
    n = cyc;
    fork
      begin
        bus.rx = 1'b0;
        idle(20);
        bus.rx = 1'b1;
      end
      begin
        wait_cyc(n + 3 + HALF - 1); chk("glitch_busy_high", int'(bus.rx_busy), 1);
        wait_cyc(n + 3 + HALF);     chk("glitch_busy_fall", int'(bus.rx_busy), 0);
      end
    join
    idle(100);

    // 4: framing error, then stuck-low line must not restart
    send_byte(8'h3C, BIT, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(100);
      chk("stuck_low_no_busy", int'(bus.rx_busy), 0);
    end
    chk("ferr_keeps_data", int'(bus.rx_data), 8'hFF);
    bus.rx = 1'b1;
    idle(20);
    send_byte(8'h3C, BIT, 1'b1, 1'b1);
    idle(30);

    // 5: asynchronous reset during data bit 4
    n = cyc;
    fork
      send_byte(8'hC3, BIT, 1'b1, 1'b0);
      begin
        wait_cyc(n + 3 + HALF + 5 * BIT);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_rx_data", int'(bus.rx_data), 0);
        chk("midreset_rx_valid", int'(bus.rx_valid), 0);
        chk("midreset_rx_ferr", int'(bus.rx_frame_error), 0);
        chk("midreset_rx_busy", int'(bus.rx_busy), 0);
      end
    join
    last_good = 8'h00;
    idle(3);
    rst = 1'b0;
    idle(10);
    send_byte(8'h81, BIT, 1'b1, 1'b1);
    idle(30);

    // 6: sender bit period -2% and +2%
    send_byte(8'h55, 98, 1'b1, 1'b1);
    idle(50);
    send_byte(8'h55, 102, 1'b1, 1'b1);
    idle(50);

    chk("final_rx_data", int'(bus.rx_data), 8'h55);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
